// File: rtl/filter_demux_pkg.sv
// Shared types and helpers for the filter-slot demux sequencer.
package filter_demux_pkg;

  typedef enum logic {PARALLEL = 1'b0, SERIAL = 1'b1} mode_e;
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  // Upper bound on OUT_CH supported by the one-hot decoder.
  localparam int ONEHOT_MAX = 1024;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int bits_for(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // One-hot of idx within out_ch channels; all zero when idx is out of range.
  function automatic logic [ONEHOT_MAX-1:0] onehot_dec(input int idx, input int out_ch);
    logic [ONEHOT_MAX-1:0] r;
    r = '0;
    if ((idx >= 0) && (idx < out_ch) && (idx < ONEHOT_MAX)) r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/filter_demux_seq_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is pure data: emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/filter_demux_seq.sv
// Buffers filter-index requests and issues registered one-hot demux selects,
// all slots in one beat (parallel) or one slot per beat (serial).
module filter_demux_seq
  import filter_demux_pkg::*;
#(
  parameter int  NUM_MACRO      = 1,
  parameter int  OUT_CH         = 64,
  parameter int  MAX_NUM_FILTER = 4,
  parameter int  FIFO_DEPTH     = 4,
  localparam int BIT_OUT_CH     = bits_for(OUT_CH),
  localparam int BIT_CNT        = bits_for(MAX_NUM_FILTER + 1),
  localparam int NF             = NUM_MACRO * MAX_NUM_FILTER
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NF*BIT_OUT_CH-1:0] which_filter,
  input  logic [BIT_CNT-1:0]       filter_cnt,
  input  logic                     mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_CH*NF-1:0]     demux,
  output logic                     out_last,
  output logic                     err,
  input  logic                     err_clr
);

  localparam int WF_W    = NF * BIT_OUT_CH;
  localparam int DEMUX_W = OUT_CH * NF;

  typedef struct packed {
    logic [WF_W-1:0]    wf;
    logic [BIT_CNT-1:0] cnt;
    mode_e              mode;
  } req_t;

  function automatic logic [BIT_CNT-1:0] sat_cnt(input logic [BIT_CNT-1:0] c);
    if (int'(c) > MAX_NUM_FILTER) return BIT_CNT'(MAX_NUM_FILTER);
    return c;
  endfunction

  state_e               state_q, state_d;
  logic [BIT_CNT-1:0]   k_q, k_d;
  req_t                 cur_q, cur_d;
  logic                 out_valid_q, out_valid_d;
  logic [DEMUX_W-1:0]   demux_q, demux_d;
  logic                 out_last_q, out_last_d;
  logic                 err_q, err_d;

  req_t                 fifo_wdata, fifo_rdata;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                 adv, load;
  logic [DEMUX_W-1:0]   beat_demux;
  logic                 beat_last, beat_err;

  assign in_ready        = !fifo_full;
  assign fifo_push       = in_valid && in_ready;
  assign fifo_wdata.wf   = which_filter;
  assign fifo_wdata.cnt  = sat_cnt(filter_cnt);
  assign fifo_wdata.mode = mode_e'(mode);
  assign adv             = !out_valid_q || out_ready;

  assign out_valid = out_valid_q;
  assign demux     = demux_q;
  assign out_last  = out_last_q;
  assign err       = err_q;

  sync_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      demux_q     <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      demux_q     <= demux_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    cur_q <= cur_d;
  end

  // Next-state: continue the current request, else pop the next one, else idle
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cur_d    = cur_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    if (adv) begin
      if ((state_q == ISSUE) && !out_last_q) begin
        k_d  = k_q + BIT_CNT'(1);
        load = 1'b1;
      end else if (!fifo_empty) begin
        state_d  = ISSUE;
        k_d      = '0;
        cur_d    = fifo_rdata;
        fifo_pop = 1'b1;
        load     = 1'b1;
      end else begin
        state_d = IDLE;
        k_d     = '0;
      end
    end
  end

  // Output: decode the beat selected by the next-state values
  always_comb begin
    int idx;
    idx        = 0;
    beat_demux = '0;
    beat_err   = 1'b0;
    beat_last  = (cur_d.mode == PARALLEL) || (cur_d.cnt == '0) ||
                 ((k_d + BIT_CNT'(1)) == cur_d.cnt);
    for (int m = 0; m < NUM_MACRO; m++) begin
      for (int s = 0; s < MAX_NUM_FILTER; s++) begin
        if ((s < int'(cur_d.cnt)) && ((cur_d.mode == PARALLEL) || (s == int'(k_d)))) begin
          idx = int'(cur_d.wf[(m*MAX_NUM_FILTER+s)*BIT_OUT_CH +: BIT_OUT_CH]);
          beat_demux[(m*MAX_NUM_FILTER+s)*OUT_CH +: OUT_CH] = OUT_CH'(onehot_dec(idx, OUT_CH));
          if (idx >= OUT_CH) beat_err = 1'b1;
        end
      end
    end

    out_valid_d = out_valid_q;
    demux_d     = demux_q;
    out_last_d  = out_last_q;
    if (load) begin
      out_valid_d = 1'b1;
      demux_d     = beat_demux;
      out_last_d  = beat_last;
    end else if (adv) begin
      out_valid_d = 1'b0;
      demux_d     = '0;
      out_last_d  = 1'b0;
    end

    // A new error outranks a same-cycle clear.
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (load && beat_err) err_d = 1'b1;
  end

endmodule

// File: tb/tb_filter_demux_seq.sv
// Directed bench: dut A uses default parameters, dut B has two macros and 48 channels.
module tb_filter_demux_seq;

  localparam int DW = 384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, in_valid, mode, out_ready, err_clr;
  logic [2:0]  filter_cnt;
  logic [47:0] wf;

  logic           in_ready_a, out_valid_a, out_last_a, err_a;
  logic [255:0]   demux_a;
  logic           in_ready_b, out_valid_b, out_last_b, err_b;
  logic [DW-1:0]  demux_b;

  logic           cur_in_ready, cur_out_valid, cur_out_last, cur_err;
  logic [DW-1:0]  cur_demux;

  assign cur_in_ready  = sel ? in_ready_b  : in_ready_a;
  assign cur_out_valid = sel ? out_valid_b : out_valid_a;
  assign cur_out_last  = sel ? out_last_b  : out_last_a;
  assign cur_err       = sel ? err_b       : err_a;
  assign cur_demux     = sel ? demux_b     : {128'b0, demux_a};

  filter_demux_seq #(.NUM_MACRO(1), .OUT_CH(64), .MAX_NUM_FILTER(4), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(in_ready_a),
    .which_filter(wf[23:0]), .filter_cnt(filter_cnt), .mode(mode),
    .out_valid(out_valid_a), .out_ready(out_ready && !sel), .demux(demux_a),
    .out_last(out_last_a), .err(err_a), .err_clr(err_clr && !sel));

  filter_demux_seq #(.NUM_MACRO(2), .OUT_CH(48), .MAX_NUM_FILTER(4), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(in_ready_b),
    .which_filter(wf), .filter_cnt(filter_cnt), .mode(mode),
    .out_valid(out_valid_b), .out_ready(out_ready && sel), .demux(demux_b),
    .out_last(out_last_b), .err(err_b), .err_clr(err_clr && sel));

  typedef struct packed {
    logic               sel;
    logic               md;
    logic [2:0]         cnt;
    logic [47:0]        w;
    logic [2:0]         nb;
    logic               e;
    logic [3:0][DW-1:0] ex;
  } vec_t;

  vec_t vt [9];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   nb, acc, seen;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] hb(input int p0, input int p1, input int p2, input int p3);
    logic [DW-1:0] r;
    r = '0;
    if (p0 >= 0) r[p0] = 1'b1;
    if (p1 >= 0) r[p1] = 1'b1;
    if (p2 >= 0) r[p2] = 1'b1;
    if (p3 >= 0) r[p3] = 1'b1;
    return r;
  endfunction

  function automatic logic [47:0] wf8(input int a0, input int a1, input int a2, input int a3,
                                      input int a4, input int a5, input int a6, input int a7);
    return {6'(a7), 6'(a6), 6'(a5), 6'(a4), 6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input int i, input logic s, input logic md, input int c,
                      input logic [47:0] w, input int n, input logic e,
                      input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    vt[i].sel   = s;
    vt[i].md    = md;
    vt[i].cnt   = 3'(c);
    vt[i].w     = w;
    vt[i].nb    = 3'(n);
    vt[i].e     = e;
    vt[i].ex[0] = e0;
    vt[i].ex[1] = e1;
    vt[i].ex[2] = e2;
    vt[i].ex[3] = '0;
  endtask

  // Offer one request and return just after the edge that accepts it.
  task automatic send_req(input logic s, input logic [47:0] w, input logic [2:0] c, input logic md);
    sel        = s;
    wf         = w;
    filter_cnt = c;
    mode       = md;
    in_valid   = 1'b1;
    for (int i = 0; i < 20 && !cur_in_ready; i++) step();
    chk1("send_ready", cur_in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b0;
    err_clr = 1'b0; filter_cnt = '0; wf = '0;

    setv(0, 0, 0, 1, wf8(5, 0, 0, 0, 0, 0, 0, 0),   1, 0, hb(5, -1, -1, -1), '0, '0);
    setv(1, 0, 0, 3, wf8(0, 17, 63, 3, 0, 0, 0, 0), 1, 0, hb(0, 81, 191, -1), '0, '0);
    setv(2, 0, 1, 3, wf8(0, 17, 63, 3, 0, 0, 0, 0), 3, 0,
         hb(0, -1, -1, -1), hb(81, -1, -1, -1), hb(191, -1, -1, -1));
    setv(3, 0, 0, 0, wf8(5, 6, 7, 8, 0, 0, 0, 0),   1, 0, '0, '0, '0);
    setv(4, 0, 1, 0, wf8(5, 6, 7, 8, 0, 0, 0, 0),   1, 0, '0, '0, '0);
    setv(5, 0, 0, 7, wf8(1, 2, 3, 4, 0, 0, 0, 0),   1, 0, hb(1, 66, 131, 196), '0, '0);
    setv(6, 1, 0, 2, wf8(5, 47, 9, 9, 0, 10, 9, 9), 1, 0, hb(5, 95, 192, 250), '0, '0);
    setv(7, 1, 1, 2, wf8(5, 47, 9, 9, 0, 10, 9, 9), 2, 0,
         hb(5, 192, -1, -1), hb(95, 250, -1, -1), '0);
    setv(8, 1, 0, 1, wf8(50, 0, 0, 0, 2, 0, 0, 0), 1, 1, hb(194, -1, -1, -1), '0, '0);

    step(); step(); step();
    rst = 1'b0;
    step();
    chk1("rst_in_ready_a", in_ready_a, 1'b1);
    chk1("rst_out_valid_a", out_valid_a, 1'b0);
    chkv("rst_demux_a", {128'b0, demux_a}, '0);
    chk1("rst_out_last_a", out_last_a, 1'b0);
    chk1("rst_err_a", err_a, 1'b0);
    chk1("rst_in_ready_b", in_ready_b, 1'b1);
    chk1("rst_out_valid_b", out_valid_b, 1'b0);
    chkv("rst_demux_b", demux_b, '0);

    for (int i = 0; i < 9; i++) begin
      out_ready = 1'b1;
      send_req(vt[i].sel, vt[i].w, vt[i].cnt, vt[i].md);
      chk1($sformatf("v%0d_idle_at_accept", i), cur_out_valid, 1'b0);
      step();
      chk1($sformatf("v%0d_valid_next", i), cur_out_valid, 1'b1);
      nb = 0;
      for (int c = 0; c < 8 && cur_out_valid; c++) begin
        if (nb < 4) begin
          chkv($sformatf("v%0d_beat%0d", i, nb), cur_demux, vt[i].ex[nb]);
          chk1($sformatf("v%0d_last%0d", i, nb), cur_out_last, nb == int'(vt[i].nb) - 1);
        end
        nb++;
        step();
      end
      chki($sformatf("v%0d_beats", i), nb, int'(vt[i].nb));
      chk1($sformatf("v%0d_err", i), cur_err, vt[i].e);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
    end

    // Serial beats held under three stall cycles each
    out_ready = 1'b0;
    send_req(1'b0, wf8(0, 17, 63, 3, 0, 0, 0, 0), 3'd3, 1'b1);
    step();
    for (int b = 0; b < 3; b++) begin
      for (int c = 0; c < 3; c++) begin
        chk1($sformatf("bp_valid%0d_%0d", b, c), cur_out_valid, 1'b1);
        chkv($sformatf("bp_demux%0d_%0d", b, c), cur_demux,
             (b == 0) ? hb(0, -1, -1, -1) : (b == 1) ? hb(81, -1, -1, -1) : hb(191, -1, -1, -1));
        chk1($sformatf("bp_last%0d_%0d", b, c), cur_out_last, b == 2);
        step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk1("bp_done", cur_out_valid, 1'b0);

    // FIFO full: the first request moves into the output register, so
    // four more fill the FIFO and the sixth is refused.
    sel = 1'b0;
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid   = 1'b1;
      wf         = wf8(10 + acc, 0, 0, 0, 0, 0, 0, 0);
      filter_cnt = 3'd1;
      mode       = 1'b0;
      if (cur_in_ready) acc++;
      step();
    end
    chki("full_accepted", acc, 5);
    chk1("full_in_ready", cur_in_ready, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    nb = 0;
    for (int c = 0; c < 12 && cur_out_valid; c++) begin
      if (nb < 5) chkv($sformatf("drain%0d", nb), cur_demux, hb(10 + nb, -1, -1, -1));
      nb++;
      step();
    end
    chki("drain_count", nb, 5);

    // Sticky error, clear, and set-beats-clear on the same edge
    out_ready = 1'b1;
    send_req(1'b1, wf8(50, 0, 0, 0, 2, 0, 0, 0), 3'd1, 1'b0);
    chk1("err_before_load", cur_err, 1'b0);
    step();
    chk1("err_set", cur_err, 1'b1);
    chkv("err_demux", cur_demux, hb(194, -1, -1, -1));
    step(); step();
    chk1("err_sticky", cur_err, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk1("err_cleared", cur_err, 1'b0);
    send_req(1'b1, wf8(50, 0, 0, 0, 2, 0, 0, 0), 3'd1, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk1("err_set_wins", cur_err, 1'b1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Reset during beat 1 of a 4-beat serial request with another queued
    out_ready = 1'b1;
    send_req(1'b1, wf8(1, 2, 3, 4, 5, 6, 7, 8), 3'd4, 1'b1);
    send_req(1'b1, wf8(9, 9, 9, 9, 9, 9, 9, 9), 3'd1, 1'b0);
    chkv("mid_beat0", cur_demux, hb(1, 197, -1, -1));
    step();
    chkv("mid_beat1", cur_demux, hb(50, 246, -1, -1));
    chk1("mid_last1", cur_out_last, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk1("arst_valid", cur_out_valid, 1'b0);
    chkv("arst_demux", cur_demux, '0);
    chk1("arst_last", cur_out_last, 1'b0);
    chk1("arst_in_ready", cur_in_ready, 1'b1);
    step(); step();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (cur_out_valid) seen++;
      step();
    end
    chki("post_rst_beats", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
